int_master: RTL and testbench

- SPI master that drives the function generator's register interface from the host side: int_clk, int_mosi, int_cs, int_miso.
- Converts a single-cycle register read or write request into one 32-bit serial frame.
- On reads, returns the captured 24-bit data.
- Used as the bench-side driver for the interface and in controller FPGAs that configure the generator.

---
 rtl/int_master.sv | 195 +++++++++++++++++++
 tb/tb_int_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_master.sv
// SPI mode-0 master for the function generator register port.
// One request becomes one 32-bit frame: {read_flag, addr, data}, MSB first.
module int_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_i,
  input  logic                  req_i,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  int_clk_o,
  output logic                  int_mosi_o,
  input  logic                  int_miso_i,
  output logic                  int_cs_o
);

  localparam int unsigned FRAME_LEN = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned DIV_W     = $clog2(CLK_DIV);
  localparam int unsigned BIT_W     = $clog2(FRAME_LEN);

  if (CLK_DIV < 2) begin : g_div_check
    $error("int_master: CLK_DIV must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [FRAME_LEN-2:0]   tx_q, tx_d;
  logic [DATA_WIDTH-1:0]  rx_q, rx_d;
  logic                   we_q, we_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [DATA_WIDTH-1:0]  rd_q, rd_d;
  logic                   sclk_q, sclk_d;
  logic                   mosi_q, mosi_d;
  logic                   cs_q, cs_d;

  logic                   div_last_c;
  logic [DATA_WIDTH-1:0]  wdata_c;
  logic [FRAME_LEN-1:0]   frame_c;

  assign div_last_c = (div_q == DIV_W'(CLK_DIV - 1));
  assign wdata_c    = req_we_i ? req_data_i : DATA_WIDTH'(0);
  assign frame_c    = {~req_we_i, req_addr_i, wdata_c};

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_d    = rd_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        // The done cycle itself never accepts, so frames are spaced by one idle cycle.
        if (req_i && !done_q) begin
          tx_d    = frame_c[FRAME_LEN-2:0];
          mosi_d  = frame_c[FRAME_LEN-1];
          we_d    = req_we_i;
          bit_d   = BIT_W'(FRAME_LEN - 1);
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        div_d = div_q + DIV_W'(1);
        if (div_last_c) begin
          div_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        div_d = div_q + DIV_W'(1);
        if (div_last_c) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[DATA_WIDTH-2:0], int_miso_i};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == '0) begin
              state_d = S_HOLD;
            end else begin
              mosi_d = tx_q[FRAME_LEN-2];
              tx_d   = {tx_q[FRAME_LEN-3:0], 1'b0};
              bit_d  = bit_q - BIT_W'(1);
            end
          end
        end
      end

      S_HOLD: begin
        div_d = div_q + DIV_W'(1);
        if (div_last_c) begin
          div_d   = '0;
          cs_d    = 1'b1;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        div_d = div_q + DIV_W'(1);
        if (div_last_c) begin
          div_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
          if (!we_q) begin
            rd_d = rx_q;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        div_d   = '0;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
        cs_d    = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rd_data_o  = rd_q;
  assign int_clk_o  = sclk_q;
  assign int_mosi_o = mosi_q;
  assign int_cs_o   = cs_q;

  // MOSI must hold through every SCLK high phase; SCLK only toggles with CS asserted
  a_mosi_stable : assert property (@(posedge sys_clk_i) disable iff (sys_rst_i)
    (sclk_q && $past(sclk_q)) |-> $stable(mosi_q));
  a_sclk_in_cs : assert property (@(posedge sys_clk_i) disable iff (sys_rst_i)
    sclk_q |-> !cs_q);

endmodule

// File: tb/tb_int_master.sv
// Randomized bench for int_master: a mode-0 slave model and a frame-level reference.
module tb_int_master;

  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [6:0]  addr = '0;
  logic [23:0] data = '0;
  logic        miso = 1'b0;
  logic        sel = 1'b0;
  int          cdiv = 4;

  logic        req4, req2;
  logic        busy4, done4, sclk4, mosi4, cs4;
  logic        busy2, done2, sclk2, mosi2, cs2;
  logic [23:0] rd4, rd2;
  logic        busy, done, sclk, mosi, cs;
  logic [23:0] rd;

  assign req4 = req & ~sel;
  assign req2 = req & sel;
  assign busy = sel ? busy2 : busy4;
  assign done = sel ? done2 : done4;
  assign sclk = sel ? sclk2 : sclk4;
  assign mosi = sel ? mosi2 : mosi4;
  assign cs   = sel ? cs2   : cs4;
  assign rd   = sel ? rd2   : rd4;

  int_master #(.CLK_DIV(4)) u_dut4 (
    .sys_clk_i(clk), .sys_rst_i(rst), .req_i(req4), .req_we_i(we),
    .req_addr_i(addr), .req_data_i(data), .busy_o(busy4), .done_o(done4),
    .rd_data_o(rd4), .int_clk_o(sclk4), .int_mosi_o(mosi4),
    .int_miso_i(miso), .int_cs_o(cs4));

  int_master #(.CLK_DIV(2)) u_dut2 (
    .sys_clk_i(clk), .sys_rst_i(rst), .req_i(req2), .req_we_i(we),
    .req_addr_i(addr), .req_data_i(data), .busy_o(busy2), .done_o(done2),
    .rd_data_o(rd2), .int_clk_o(sclk2), .int_mosi_o(mosi2),
    .int_miso_i(miso), .int_cs_o(cs2));

  int total = 0;
  int bad = 0;

  // Bus monitor and slave model, evaluated between rising edges
  int          ncyc = 0, pulses = 0, dones = 0, cs_falls = 0, glitches = 0, per_err = 0;
  int          last_rise = -1, fall_cyc = 0, done_cyc = 0, cs_hi_run = 0, hi_before_fall = 0;
  logic [31:0] cap = '0, slave_frame = '0, slave_sh = '0;
  logic        hi_mosi = 1'b0, sclk_p = 1'b0, cs_p = 1'b1;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (sclk && !sclk_p) begin
      cap = {cap[30:0], mosi};
      if (last_rise >= 0 && (ncyc - last_rise) != 2 * cdiv) per_err = per_err + 1;
      last_rise = ncyc;
      pulses = pulses + 1;
      hi_mosi = mosi;
    end else if (sclk && sclk_p && mosi !== hi_mosi) begin
      glitches = glitches + 1;
    end
    if (!cs && cs_p) begin
      cs_falls = cs_falls + 1;
      fall_cyc = ncyc;
      hi_before_fall = cs_hi_run;
      last_rise = -1;
      slave_sh = slave_frame;
      miso = slave_sh[31];
    end else if (!cs && !sclk && sclk_p) begin
      slave_sh = {slave_sh[30:0], 1'b0};
      miso = slave_sh[31];
    end
    if (done) begin
      dones = dones + 1;
      done_cyc = ncyc;
    end
    cs_hi_run = cs ? cs_hi_run + 1 : 0;
    sclk_p = sclk;
    cs_p = cs;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_frame(input logic w, input logic [6:0] a, input logic [23:0] d);
    return {~w, a, (w ? d : 24'h0)};
  endfunction

  function automatic int ref_latency();
    return (2 * 32 + 3) * cdiv + 1;
  endfunction

  // Runs one transaction from an idle DUT and reports what the bus showed.
  task automatic do_frame(input logic w, input logic [6:0] a, input logic [23:0] d,
                          input logic [23:0] sd, input bit coll,
                          output int lat, output int npulse, output int ndone,
                          output logic [31:0] frame, output int nglitch, output int nper,
                          output logic [23:0] rd_at_done);
    int p0, d0, g0, e0;
    p0 = pulses; d0 = dones; g0 = glitches; e0 = per_err;
    slave_frame = {8'($urandom), sd};
    req = 1'b1; we = w; addr = a; data = d;
    tick();
    lat = 1;
    req = 1'b0;
    we = 1'($urandom); addr = 7'($urandom); data = 24'($urandom);
    while (!done && lat < LIMIT) begin
      tick();
      lat = lat + 1;
      if (coll) req = (lat == 10 || lat == 100);
    end
    rd_at_done = rd;
    req = 1'b0;
    tick();
    tick();
    npulse = pulses - p0;
    ndone = dones - d0;
    frame = cap;
    nglitch = glitches - g0;
    nper = per_err - e0;
  endtask

  logic [23:0] exp_rd = '0;

  task automatic test_reset();
    sel = 1'b0; cdiv = 4;
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = 7'h12;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (rd !== 24'h0) begin bad++; $display("FAIL reset_rd got=%h exp=000000", rd); end
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    total++; if (mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    total++; if (cs !== 1'b1) begin bad++; $display("FAIL reset_cs got=%b exp=1", cs); end
    rst = 1'b0; req = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b0 || cs !== 1'b1) begin
      bad++; $display("FAIL reset_req_dropped busy=%b cs=%b exp busy=0 cs=1", busy, cs);
    end
    exp_rd = '0;
  endtask

  task automatic check_frame(input string nm, input logic w, input logic [6:0] a, input logic [23:0] d,
                             input int lat, input int np, input int nd, input logic [31:0] fr,
                             input int ng, input int ne, input logic [23:0] rdd);
    logic [31:0] ef;
    ef = ref_frame(w, a, d);
    total++; if (fr !== ef) begin bad++; $display("FAIL %s_frame got=%h exp=%h", nm, fr, ef); end
    total++; if (lat != ref_latency()) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, ref_latency()); end
    total++; if (np != 32) begin bad++; $display("FAIL %s_pulses got=%0d exp=32", nm, np); end
    total++; if (nd != 1) begin bad++; $display("FAIL %s_dones got=%0d exp=1", nm, nd); end
    total++; if (ng != 0 || ne != 0) begin bad++; $display("FAIL %s_sclk_mosi glitches=%0d period_errs=%0d exp=0", nm, ng, ne); end
    total++; if (rdd !== exp_rd) begin bad++; $display("FAIL %s_rd_data got=%h exp=%h", nm, rdd, exp_rd); end
  endtask

  task automatic test_write();
    int lat, np, nd, ng, ne;
    logic [31:0] fr;
    logic [23:0] rdd, d;
    logic [6:0] a;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 7'h05 : 7'($urandom);
      d = (i == 0) ? 24'hA5A5A5 : 24'($urandom);
      do_frame(1'b1, a, d, 24'($urandom), 1'b0, lat, np, nd, fr, ng, ne, rdd);
      check_frame("write", 1'b1, a, d, lat, np, nd, fr, ng, ne, rdd);
    end
  endtask

  task automatic test_read();
    int lat, np, nd, ng, ne;
    logic [31:0] fr;
    logic [23:0] rdd, sd;
    logic [6:0] a;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 7'h12 : 7'($urandom);
      sd = (i == 0) ? 24'h123456 : 24'($urandom);
      exp_rd = sd;
      do_frame(1'b0, a, 24'($urandom), sd, 1'b0, lat, np, nd, fr, ng, ne, rdd);
      check_frame("read", 1'b0, a, 24'h0, lat, np, nd, fr, ng, ne, rdd);
    end
  endtask

  task automatic test_collision();
    int lat, np, nd, ng, ne, f0, d0;
    logic [31:0] fr;
    logic [23:0] rdd, d;
    logic [6:0] a;
    a = 7'($urandom); d = 24'($urandom);
    do_frame(1'b1, a, d, 24'($urandom), 1'b1, lat, np, nd, fr, ng, ne, rdd);
    check_frame("collide", 1'b1, a, d, lat, np, nd, fr, ng, ne, rdd);
    f0 = cs_falls; d0 = dones;
    for (int i = 0; i < 300; i++) tick();
    total++; if (cs_falls != f0 || dones != d0) begin
      bad++; $display("FAIL collide_queued extra_frames=%0d extra_dones=%0d exp=0", cs_falls - f0, dones - d0);
    end
  endtask

  task automatic test_back_to_back();
    int d0, f0, p0, n;
    logic [31:0] ef;
    d0 = dones; f0 = cs_falls; p0 = pulses;
    we = 1'b1; addr = 7'($urandom); data = 24'($urandom);
    slave_frame = 32'($urandom);
    ef = ref_frame(1'b1, addr, data);
    req = 1'b1;
    n = 0;
    while (cs_falls < f0 + 2 && n < LIMIT) begin tick(); n++; end
    req = 1'b0;
    total++; if (cs_falls != f0 + 2) begin bad++; $display("FAIL b2b_second_frame cs_falls=%0d exp=%0d", cs_falls - f0, 2); end
    total++; if (fall_cyc - done_cyc != 2) begin
      bad++; $display("FAIL b2b_cs_gap got=%0d exp=2", fall_cyc - done_cyc);
    end
    total++; if (hi_before_fall < cdiv) begin
      bad++; $display("FAIL b2b_cs_high got=%0d exp>=%0d", hi_before_fall, cdiv);
    end
    n = 0;
    while (dones < d0 + 2 && n < LIMIT) begin tick(); n++; end
    tick(); tick();
    total++; if (dones - d0 != 2 || pulses - p0 != 64) begin
      bad++; $display("FAIL b2b_count dones=%0d pulses=%0d exp 2 and 64", dones - d0, pulses - p0);
    end
    total++; if (cap !== ef) begin bad++; $display("FAIL b2b_frame got=%h exp=%h", cap, ef); end
  endtask

  task automatic test_reset_mid();
    int lat, np, nd, ng, ne, p0, d0, n;
    logic [31:0] fr;
    logic [23:0] rdd, sd;
    logic [6:0] a;
    p0 = pulses; d0 = dones;
    slave_frame = 32'($urandom);
    req = 1'b1; we = 1'b0; addr = 7'($urandom);
    tick();
    req = 1'b0;
    n = 0;
    while (pulses - p0 < 10 && n < LIMIT) begin tick(); n++; end
    rst = 1'b1;
    tick();
    total++; if (cs !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_bus cs=%b sclk=%b busy=%b exp 1 0 0", cs, sclk, busy);
    end
    total++; if (rd !== 24'h0) begin bad++; $display("FAIL midrst_rd got=%h exp=000000", rd); end
    rst = 1'b0;
    exp_rd = '0;
    for (int i = 0; i < 400; i++) tick();
    total++; if (dones != d0) begin bad++; $display("FAIL midrst_done got=%0d exp=0", dones - d0); end
    a = 7'($urandom); sd = 24'($urandom);
    exp_rd = sd;
    do_frame(1'b0, a, 24'h0, sd, 1'b0, lat, np, nd, fr, ng, ne, rdd);
    check_frame("after_rst", 1'b0, a, 24'h0, lat, np, nd, fr, ng, ne, rdd);
  endtask

  task automatic test_div2();
    int lat, np, nd, ng, ne;
    logic [31:0] fr;
    logic [23:0] rdd;
    logic [6:0] a;
    rst = 1'b1; tick(); tick();
    sel = 1'b1; cdiv = 2;
    rst = 1'b0; tick(); tick();
    exp_rd = 24'hFFFFFF;
    a = 7'($urandom);
    do_frame(1'b0, a, 24'h0, 24'hFFFFFF, 1'b0, lat, np, nd, fr, ng, ne, rdd);
    check_frame("div2", 1'b0, a, 24'h0, lat, np, nd, fr, ng, ne, rdd);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_div2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
